// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, with optional
// signed operands, start/busy/done handshake and synchronous abort.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one partial product per edge, cnt = bit being processed
// FIN   | sign fix-up, result written to yout, done pulsed
module seq_mult_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sgn,
  input  logic               abort,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] yout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] yout_q, yout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               sgn_eff;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] pp;

  assign sgn_eff = sgn & SIGNED_EN;
  assign a_neg   = sgn_eff & ain[WIDTH-1];
  assign b_neg   = sgn_eff & bin[WIDTH-1];
  assign pp      = {{WIDTH{1'b0}}, ma_q} << cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    yout_d  = yout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort here
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          ma_d    = a_neg ? -ain : ain;
          mb_d    = b_neg ? -bin : bin;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          if (mb_q[cnt_q]) acc_d = acc_q + pp;
          if (cnt_q == LAST) begin
            state_d = FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (abort) begin
          acc_d = '0;
        end else begin
          yout_d = neg_q ? -acc_q : acc_q;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      yout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      yout_q  <= yout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign yout = yout_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: three instances (16-bit signed, 16-bit unsigned-only,
// 8-bit signed) checked against integer multiplication and the fixed latency.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sgn, abort;
  logic [15:0] ain, bin;
  int          sel;

  logic        st0, st1, st2;
  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] yout0, yout1;
  logic [15:0] yout2;
  logic        busy_s, done_s;
  logic [31:0] yout_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign st0 = start & (sel == 0);
  assign st1 = start & (sel == 1);
  assign st2 = start & (sel == 2);

  assign busy_s = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign done_s = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign yout_s = (sel == 0) ? yout0 : (sel == 1) ? yout1 : {16'h0, yout2};

  seq_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .start(st0), .sgn(sgn), .abort(abort),
    .ain(ain), .bin(bin), .busy(busy0), .done(done0), .yout(yout0));

  seq_mult_param #(.WIDTH(16), .SIGNED_EN(1'b0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .start(st1), .sgn(sgn), .abort(abort),
    .ain(ain), .bin(bin), .busy(busy1), .done(done1), .yout(yout1));

  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(st2), .sgn(sgn), .abort(abort),
    .ain(ain[7:0]), .bin(bin[7:0]), .busy(busy2), .done(done2), .yout(yout2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer product of the operands as the selected instance sees them
  function automatic logic [31:0] model(input int sl, input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    longint p;
    if (sl == 2) begin
      if (s) p = longint'($signed(a[7:0])) * longint'($signed(b[7:0]));
      else   p = longint'(a[7:0]) * longint'(b[7:0]);
      return {16'h0, p[15:0]};
    end
    if (sl == 0 && s) p = longint'($signed(a)) * longint'($signed(b));
    else              p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int lat_of(input int sl);
    return (sl == 2) ? 9 : 17;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int sl, input logic [15:0] a, input logic [15:0] b, input logic s);
    sel   = sl;
    ain   = a;
    bin   = b;
    sgn   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] y, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done_s && lat < 200) begin
      if (busy_s) bc++;
      tick();
      lat++;
    end
    if (!done_s) check("done_timeout", done_s, 1);
    y = yout_s;
  endtask

  task automatic run_op(input string tag, input int sl, input logic [15:0] a,
                        input logic [15:0] b, input logic s);
    logic [31:0] y;
    int lat, bc;
    launch(sl, a, b, s);
    wait_done(y, lat, bc);
    check({tag, "_y"}, y, model(sl, a, b, s));
    check({tag, "_lat"}, lat, lat_of(sl));
    check({tag, "_busy"}, bc, lat_of(sl));
    check({tag, "_busy_at_done"}, busy_s, 1'b0);
  endtask

  initial begin
    logic [31:0] y;
    int lat, bc, dc;
    logic [15:0] corners [8];
    logic [15:0] a, b;

    corners = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0080, 16'h00FF, 16'h007F};
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; abort = 1'b0; ain = '0; bin = '0; sel = 0;
    repeat (3) tick();
    check("rst_busy0", busy0, 0);  check("rst_done0", done0, 0);  check("rst_yout0", yout0, 0);
    check("rst_busy2", busy2, 0);  check("rst_yout2", yout2, 0);
    rst_n = 1'b1;
    tick();

    run_op("u_ffff", 0, 16'hFFFF, 16'hFFFF, 1'b0);
    check("u_ffff_const", yout_s, 32'hFFFE0001);
    run_op("s_m3x5", 0, 16'hFFFD, 16'h0005, 1'b1);
    check("s_m3x5_const", yout_s, 32'hFFFFFFF1);
    run_op("s_min2", 0, 16'h8000, 16'h8000, 1'b1);
    check("s_min2_const", yout_s, 32'h40000000);
    run_op("s_minx1", 0, 16'h8000, 16'h0001, 1'b1);
    check("s_minx1_const", yout_s, 32'hFFFF8000);
    run_op("nosgn_min2", 1, 16'h8000, 16'h8000, 1'b1);
    check("nosgn_min2_const", yout_s, 32'h40000000);
    run_op("nosgn_m3x5", 1, 16'hFFFD, 16'h0005, 1'b1);

    // start mid-run ignored, then back-to-back start during the done cycle
    launch(0, 16'd7, 16'd9, 1'b0);
    repeat (3) tick();
    ain = 16'd2; bin = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(y, lat, bc);
    check("hs_7x9_y", y, 32'd63);
    check("hs_7x9_lat", lat + 4, 17);
    launch(0, 16'd2, 16'd2, 1'b0);
    check("b2b_accept_busy", busy_s, 1'b1);
    wait_done(y, lat, bc);
    check("b2b_y", y, 32'd4);
    check("b2b_lat", lat, 17);
    tick();
    check("done_one_cycle", done_s, 1'b0);
    check("yout_held", yout_s, 32'd4);

    // abort in RUN
    launch(0, 16'h1234, 16'h5678, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_busy", busy_s, 1'b0);
    dc = 0;
    for (int i = 0; i < 25; i++) begin
      if (done_s) dc++;
      tick();
    end
    check("abort_run_nodone", dc, 0);
    check("abort_run_yout", yout_s, 32'd4);
    run_op("post_abort_3x3", 0, 16'd3, 16'd3, 1'b0);

    // abort in FIN beats the result write
    launch(0, 16'd5, 16'd5, 1'b0);
    repeat (16) tick();
    check("fin_reached_busy", busy_s, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_fin_done", done_s, 1'b0);
    check("abort_fin_busy", busy_s, 1'b0);
    check("abort_fin_yout", yout_s, 32'd9);
    tick();
    check("abort_fin_done2", done_s, 1'b0);

    // abort with start in IDLE: start wins
    abort = 1'b1;
    launch(0, 16'd6, 16'd7, 1'b0);
    abort = 1'b0;
    wait_done(y, lat, bc);
    check("abort_start_y", y, 32'd42);
    check("abort_start_lat", lat, 17);

    // async reset mid-run
    launch(0, 16'h1111, 16'h2222, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_s, 1'b0);
    check("midrst_done", done_s, 1'b0);
    check("midrst_yout", yout_s, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst_0xabcd", 0, 16'h0000, 16'hABCD, 1'b0);

    run_op("w8_m128sq", 2, 16'h0080, 16'h0080, 1'b1);
    check("w8_m128sq_const", yout_s, 32'h4000);
    run_op("w8_255sq", 2, 16'h00FF, 16'h00FF, 1'b0);
    check("w8_255sq_const", yout_s, 32'hFE01);

    // random sweep, back-to-back launches, biased towards corner operands
    for (int sl = 0; sl < 3; sl++) begin
      for (int k = 0; k < ((sl == 1) ? 300 : 1500); k++) begin
        a = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
        b = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
        launch(sl, a, b, 1'($urandom_range(0, 1)));
        wait_done(y, lat, bc);
        check("rnd_y", y, model(sl, a, b, sgn));
        check("rnd_lat", lat, lat_of(sl));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
